// File: rtl/dmux1x8_with_1x4.sv
// 1-to-8 registered demultiplexer built from two 1-to-4 banks selected by e.
// Optional macro DMUX18_HOLD_EN: sample-and-hold mode, only the addressed bit updates.

module dmux1x4 (
  input  logic       a,
  input  logic       en,
  input  logic       s1,
  input  logic       s0,
  output logic [3:0] out
);

  // Route a onto the line addressed by {s1,s0}; a disabled bank drives all zeros.
  always_comb begin
    out = 4'b0000;
    case ({s1, s0})
      2'b00:   out[0] = a & en;
      2'b01:   out[1] = a & en;
      2'b10:   out[2] = a & en;
      2'b11:   out[3] = a & en;
      default: out = 4'b0000;
    endcase
  end

endmodule

module dmux1x8_with_1x4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       s1,
  input  logic       s0,
  input  logic       e,
  output logic [7:0] y
);

  logic [3:0] lo_s;
  logic [3:0] hi_s;
  logic [7:0] y_next_s;
  logic [7:0] y_r;

  dmux1x4 u_bank_lo (
    .a   (a),
    .en  (~e),
    .s1  (s1),
    .s0  (s0),
    .out (lo_s)
  );

  dmux1x4 u_bank_hi (
    .a   (a),
    .en  (e),
    .s1  (s1),
    .s0  (s0),
    .out (hi_s)
  );

`ifdef DMUX18_HOLD_EN
  logic [7:0] sel_mask_s;

  // One-hot mask of the addressed line; only that bit is allowed to change.
  always_comb begin
    sel_mask_s = 8'h00;
    case ({e, s1, s0})
      3'd0:    sel_mask_s = 8'h01;
      3'd1:    sel_mask_s = 8'h02;
      3'd2:    sel_mask_s = 8'h04;
      3'd3:    sel_mask_s = 8'h08;
      3'd4:    sel_mask_s = 8'h10;
      3'd5:    sel_mask_s = 8'h20;
      3'd6:    sel_mask_s = 8'h40;
      3'd7:    sel_mask_s = 8'h80;
      default: sel_mask_s = 8'h00;
    endcase
  end

  // Keep unaddressed bits, replace the addressed bit with the bank output.
  always_comb begin
    y_next_s = (y_r & ~sel_mask_s) | {hi_s, lo_s};
  end
`else
  // Non-selected lines are cleared every cycle.
  always_comb begin
    y_next_s = {hi_s, lo_s};
  end
`endif

  // Output register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_r <= 8'h00;
    end else begin
      y_r <= y_next_s;
    end
  end

  assign y = y_r;

endmodule

// File: tb/tb_dmux1x8_with_1x4.sv
// Directed self-checking bench for dmux1x8_with_1x4 (default and DMUX18_HOLD_EN builds).

module tb_dmux1x8_with_1x4;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       s1;
  logic       s0;
  logic       e;
  logic [7:0] y;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_y;

  dmux1x8_with_1x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .s1    (s1),
    .s0    (s0),
    .e     (e),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
    n_cmp = n_cmp + 1;
    if (obs !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, obs, req);
    end
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] prev, input logic [2:0] idx,
                                            input logic a_v);
    logic [7:0] r;
`ifdef DMUX18_HOLD_EN
    r = prev;
`else
    r = 8'h00;
`endif
    r[idx] = a_v;
    return r;
  endfunction

  // Drive inputs, clock one edge, update the model and compare.
  task automatic step(input string tag, input logic rn, input logic [2:0] idx, input logic a_v);
    rst_n = rn;
    {e, s1, s0} = idx;
    a = a_v;
    @(posedge clk);
    #1;
    exp_y = rn ? model_next(exp_y, idx, a_v) : 8'h00;
    check(tag, y, exp_y);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_y = 8'h00;
    rst_n = 1'b0;
    a = 1'b0;
    {e, s1, s0} = 3'd0;
    @(negedge clk);

    // Reset held with live inputs, then release.
    step("rst_cyc1", 1'b0, 3'd5, 1'b1);
    step("rst_cyc2", 1'b0, 3'd5, 1'b1);
    check("rst_const", y, 8'h00);
    step("rst_release", 1'b1, 3'd5, 1'b1);
    check("rst_release_const", y, 8'h20);

`ifndef DMUX18_HOLD_EN
    // Sweep {e,s1,s0,a} = k.
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kv;
      kv = k[3:0];
      step($sformatf("sweep_k%0d", k), 1'b1, kv[3:1], kv[0]);
      if (k == 7)  check("spot_k7", y, 8'h08);
      if (k == 9)  check("spot_k9", y, 8'h10);
      if (k == 15) check("spot_k15", y, 8'h80);
    end

    // Bank isolation.
    step("bank_lo", 1'b1, 3'd3, 1'b1);
    check("bank_lo_const", y, 8'h08);
    check("bank_lo_hi_zero", {4'h0, y[7:4]}, 8'h00);
    step("bank_hi", 1'b1, 3'd7, 1'b1);
    check("bank_hi_const", y, 8'h80);
    check("bank_hi_lo_zero", {4'h0, y[3:0]}, 8'h00);

    // Mid-run reset.
    step("mid_pre", 1'b1, 3'd6, 1'b1);
    check("mid_pre_const", y, 8'h40);
    step("mid_rst", 1'b0, 3'd6, 1'b1);
    check("mid_rst_const", y, 8'h00);
    step("mid_post", 1'b1, 3'd6, 1'b1);
    check("mid_post_const", y, 8'h40);

    // Inter-edge toggle on a must not be captured.
    step("toggle_base", 1'b1, 3'd6, 1'b0);
    check("toggle_base_const", y, 8'h00);
    #2 a = 1'b1;
    #2 a = 1'b0;
    @(posedge clk);
    #1;
    check("toggle_edge", y, 8'h00);
`else
    // Sample-and-hold sequence from a clean register.
    step("hold_rst", 1'b0, 3'd0, 1'b0);
    step("hold_idx1", 1'b1, 3'd1, 1'b1);
    check("hold_idx1_const", y, 8'h02);
    step("hold_idx4", 1'b1, 3'd4, 1'b1);
    check("hold_idx4_const", y, 8'h12);
    step("hold_idx1_clr", 1'b1, 3'd1, 1'b0);
    check("hold_idx1_clr_const", y, 8'h10);

    // Inter-edge toggle in hold mode.
    step("hold_toggle_base", 1'b1, 3'd6, 1'b0);
    #2 a = 1'b1;
    #2 a = 1'b0;
    @(posedge clk);
    #1;
    check("hold_toggle_edge", y, 8'h10);

    // Reset clears all held bits.
    step("hold_set7", 1'b1, 3'd7, 1'b1);
    check("hold_set7_const", y, 8'h90);
    step("hold_mid_rst", 1'b0, 3'd7, 1'b1);
    check("hold_mid_rst_const", y, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
